// File: rtl/backoff_lock_responder.sv
// backoff_lock_responder: responder side of the try/backoff protocol, one shared lock
// arbitrated round-robin across NumClients initiators, with optional hold timeout.
module backoff_lock_responder #(
    parameter int NumClients    = 4,
    parameter int MaxHoldCycles = 1024,
    parameter int IdxWidth      = (NumClients > 1) ? $clog2(NumClients) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumClients-1:0] try_i,
    input  logic [NumClients-1:0] release_i,
    output logic [NumClients-1:0] grant_o,
    output logic [NumClients-1:0] nack_o,
    output logic                  locked_o,
    output logic [IdxWidth-1:0]   owner_o,
    output logic                  timeout_o
);
    localparam int HoldWidth = (MaxHoldCycles > 0) ? $clog2(MaxHoldCycles + 1) : 1;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   rr_q, rr_d, owner_q, owner_d, winner;
    logic [HoldWidth-1:0]  hold_q, hold_d;
    logic [NumClients-1:0] grant_q, grant_d, nack_q, nack_d, owner_mask, win_mask;
    logic                  timeout_q, timeout_d, found, owner_try, owner_rel, expire;
    int                    idx;

    // Rotating-priority scan: first requester at or above rr_q, wrapping.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NumClients; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NumClients) idx = idx - NumClients;
            if (!found && try_i[IdxWidth'(idx)]) begin
                found  = 1'b1;
                winner = IdxWidth'(idx);
            end
        end
    end

    assign win_mask   = NumClients'(1) << winner;
    assign owner_mask = NumClients'(1) << owner_q;
    assign owner_try  = try_i[owner_q];
    assign owner_rel  = release_i[owner_q];
    assign expire     = (MaxHoldCycles > 0) && (hold_q == HoldWidth'(MaxHoldCycles - 1))
                        && !owner_try && !owner_rel;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        grant_d   = '0;
        nack_d    = try_i;
        if (state_q == IDLE) begin
            if (found) begin
                grant_d = win_mask;
                nack_d  = try_i & ~win_mask;
                state_d = LOCKED;
                owner_d = winner;
                hold_d  = '0;
                rr_d    = (int'(winner) == NumClients - 1) ? '0 : winner + 1'b1;
            end
        end else begin
            grant_d = try_i & owner_mask;
            nack_d  = try_i & ~owner_mask;
            // Release beats a same-cycle owner try: the try is granted but the lock drops.
            if (owner_rel) begin
                state_d = IDLE;
                hold_d  = '0;
            end else if (owner_try) begin
                hold_d = '0;
            end else if (expire) begin
                state_d   = IDLE;
                hold_d    = '0;
                timeout_d = 1'b1;
            end else if (MaxHoldCycles > 0) begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            owner_q   <= '0;
            hold_q    <= '0;
            grant_q   <= '0;
            nack_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            nack_q    <= nack_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_o   = grant_q;
    assign nack_o    = nack_q;
    assign locked_o  = (state_q == LOCKED);
    assign owner_o   = owner_q;
    assign timeout_o = timeout_q;

`ifndef SYNTHESIS
    a_clients: assert property (@(posedge clk_i) NumClients >= 1);
    a_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(grant_o));
    a_excl: assert property (@(posedge clk_i) disable iff (!rst_ni) (grant_o & nack_o) == '0);
    a_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        locked_o |-> int'(owner_o) < NumClients);
`endif
endmodule
